rx_line_buffer: RTL and testbench
=================================

// Module: rx_line_buffer
// PURPOSE
//   Receive-side counterpart of the message ROM path. Captures bytes from the UART
//   receiver (rx_data/rx_valid) into a small RAM until a terminator arrives, then
//   presents the line through the same addr -> registered data read interface the
//   transmit ROM uses. Software/FSM consumers read the line and release it with line_ack.
// PARAMETERS
//   DEPTH   16     bytes of line storage (power of two)
//   ADDR_W  4      log2(DEPTH); width of rd_addr
//   TERM    8'h0D  line terminator byte ("\r"); never stored
//   SKIP    8'h0A  byte silently dropped in every state ("\n"); never stored
// PORTS
//   clk         in   1         system clock
//   rst_n       in   1         synchronous reset, active-low
//   rx_data     in   8         received byte, valid when rx_valid=1
//   rx_valid    in   1         one-cycle strobe per received byte
//   rd_addr     in   ADDR_W    read address into captured line
//   rd_data     out  8         registered read data (1-cycle latency)
//   line_ready  out  1         a complete line is held; buffer frozen
//   line_len    out  ADDR_W+1  stored byte count, 0..DEPTH; valid while line_ready
//   overflow    out  1         held line was truncated (more than DEPTH bytes received)
//   overrun     out  1         >=1 byte lost while line_ready=1
//   line_ack    in   1         consumer releases held line (ignored unless line_ready=1)
// BEHAVIOUR
//   Reset (rst_n=0 at clk edge): state=COLLECT, wr_ptr=0, line_ready=0, line_len=0,
//     overflow=0, overrun=0, rd_data=8'h20. RAM contents are not reset.
//   Reset mid-line discards partial line; the next byte is stored at address 0.
//   States: COLLECT, DISCARD, READY.
//   COLLECT, rx_valid=1:
//     - byte==SKIP: dropped, no state change.
//     - byte==TERM, wr_ptr==0: empty line ignored; stay in COLLECT.
//     - byte==TERM, wr_ptr>0: line_len<=wr_ptr, line_ready<=1, next state READY.
//     - other, wr_ptr<DEPTH: mem[wr_ptr]<=byte, wr_ptr<=wr_ptr+1.
//       wr_ptr is ADDR_W+1 bits wide and reaches DEPTH without wrapping.
//     - other, wr_ptr==DEPTH: byte dropped, overflow<=1, next state DISCARD.
//   DISCARD, rx_valid=1:
//     - byte==TERM: line_len<=DEPTH, line_ready<=1, next state READY.
//     - any other byte: dropped.
//   READY:
//     - RAM, line_len and overflow are frozen.
//     - rx_valid=1 with line_ack=0: non-SKIP byte dropped, overrun<=1 (sticky).
//       TERM counts as a dropped byte.
//     - line_ack=1: next cycle line_ready=0, overflow=0, overrun=0, wr_ptr=0,
//       next state COLLECT.
//     - line_ack=1 with rx_valid=1 in the same cycle: the byte is processed as in
//       COLLECT with wr_ptr=0. A data byte goes to mem[0] (wr_ptr<=1) and overrun
//       is not set. If that byte is TERM, it is an empty line and is ignored.
//     - line_ack outside READY has no effect.
//   Read port:
//     - Always active, independent of state.
//     - rd_data <= (rd_addr < line_len) ? mem[rd_addr] : 8'h20.
//       Unused slots return a space.
//     - 1-cycle latency: rd_data is updated at the clk edge after rd_addr is presented.
//     - line_len is registered, so the read compares against the registered
//       line_len value.
//   Outputs line_ready, line_len, overflow and overrun are registered.
//     line_ready rises in the cycle after the accepted TERM.
// TESTING
//   1. Send "Hi\r" -> line_ready=1 one cycle after the TERM strobe; line_len=2.
//      Read addr 0,1,2 -> 'H','i',8'h20, each on the following cycle.
//   2. Send "\r", then "A\nB\r" -> no line_ready after the first "\r".
//      Then line_len=2, contents "AB", overflow=0.
//   3. DEPTH=16: send 20x'A' then "\r" -> line_len=16, overflow=1.
//      Addr 0..15 read 'A'.
//   4. While READY send 'x' -> overrun=1, mem/line_len unchanged.
//      Pulse line_ack -> line_ready=0, overrun=0, overflow=0 next cycle.
//   5. line_ack and rx_valid('Q') in the same cycle, then "\r" -> new line:
//      line_len=1, addr 0 reads 'Q', overrun=0.
//   6. Send "Hel", drive rst_n=0 for 1 cycle, send "ok\r" -> line_len=2,
//      contents "ok". All outputs read reset values during reset.

Source files
------------

// File: rtl/rx_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : rx_line_buffer
// Description : Captures UART receive bytes into a small RAM until a line
//               terminator arrives, then holds the line for a consumer that
//               reads it through a registered addr -> data port and releases
//               it with line_ack.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_line_buffer #(
    parameter int         DEPTH  = 16,
    parameter int         ADDR_W = 4,
    parameter logic [7:0] TERM   = 8'h0D,
    parameter logic [7:0] SKIP   = 8'h0A
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              line_ready,
    output logic [ADDR_W:0]   line_len,
    output logic              overflow,
    output logic              overrun,
    input  logic              line_ack
);

    // Full-buffer count; DEPTH is a power of two so this is 1 << ADDR_W.
    localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] PTR_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [7:0]      BLANK     = 8'h20;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_DISCARD = 2'd1,
        ST_READY   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   wr_ptr_nxt;
    logic              ready_nxt;
    logic [ADDR_W:0]   len_nxt;
    logic              ovf_nxt;
    logic              ovr_nxt;
    logic [ADDR_W:0]   base_ptr;
    logic              do_collect;
    logic              mem_we;
    logic [7:0]        mem [DEPTH];
    logic              is_term;
    logic              is_skip;

    assign is_term = (rx_data == TERM);
    assign is_skip = (rx_data == SKIP);

    // Next-state and datapath decisions. An ack that coincides with a byte
    // processes that byte as if collecting from an empty buffer.
    always_comb begin
        state_nxt  = state;
        wr_ptr_nxt = wr_ptr;
        ready_nxt  = line_ready;
        len_nxt    = line_len;
        ovf_nxt    = overflow;
        ovr_nxt    = overrun;
        base_ptr   = wr_ptr;
        do_collect = 1'b0;
        mem_we     = 1'b0;

        case (state)
            ST_COLLECT: begin
                do_collect = rx_valid;
            end
            ST_DISCARD: begin
                if (rx_valid && is_term) begin
                    len_nxt   = DEPTH_CNT;
                    ready_nxt = 1'b1;
                    state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                if (line_ack) begin
                    state_nxt  = ST_COLLECT;
                    ready_nxt  = 1'b0;
                    ovf_nxt    = 1'b0;
                    ovr_nxt    = 1'b0;
                    wr_ptr_nxt = '0;
                    base_ptr   = '0;
                    do_collect = rx_valid;
                end else if (rx_valid && !is_skip) begin
                    ovr_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_COLLECT;
            end
        endcase

        if (do_collect && !is_skip) begin
            if (is_term) begin
                // An empty line (terminator with nothing stored) is ignored.
                if (base_ptr != '0) begin
                    len_nxt   = base_ptr;
                    ready_nxt = 1'b1;
                    state_nxt = ST_READY;
                end
            end else if (base_ptr != DEPTH_CNT) begin
                mem_we     = 1'b1;
                wr_ptr_nxt = base_ptr + PTR_ONE;
            end else begin
                ovf_nxt   = 1'b1;
                state_nxt = ST_DISCARD;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    // Write pointer, status outputs and the registered read port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            line_ready <= 1'b0;
            line_len   <= '0;
            overflow   <= 1'b0;
            overrun    <= 1'b0;
            rd_data    <= BLANK;
        end else begin
            wr_ptr     <= wr_ptr_nxt;
            line_ready <= ready_nxt;
            line_len   <= len_nxt;
            overflow   <= ovf_nxt;
            overrun    <= ovr_nxt;
            rd_data    <= ({1'b0, rd_addr} < line_len) ? mem[rd_addr] : BLANK;
        end
    end

    // Line storage; contents survive reset, only the pointers are cleared.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            mem[base_ptr[ADDR_W-1:0]] <= rx_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rx_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_line_buffer
// Description : Self-checking bench for rx_line_buffer: directed scenarios
//               followed by randomized traffic against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_line_buffer;

    localparam int         DEPTH = 16;
    localparam logic [7:0] TERM  = 8'h0D;
    localparam logic [7:0] SKIP  = 8'h0A;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       line_ready;
    logic [4:0] line_len;
    logic       overflow;
    logic       overrun;
    logic       line_ack;

    int errors = 0;
    int checks = 0;

    // Reference model: the line being collected is a queue; the RAM image
    // records what a reader at each address may legitimately see.
    logic [7:0] cur[$];
    logic [7:0] m_mem [DEPTH];
    int         m_len;
    bit         m_ready, m_ovf, m_ovr, m_disc;

    rx_line_buffer #(.DEPTH(DEPTH), .ADDR_W(4), .TERM(TERM), .SKIP(SKIP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .line_ready(line_ready),
        .line_len  (line_len),
        .overflow  (overflow),
        .overrun   (overrun),
        .line_ack  (line_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        cur.delete();
        m_len   = 0;
        m_ready = 0;
        m_ovf   = 0;
        m_ovr   = 0;
        m_disc  = 0;
    endtask

    task automatic model_step(input bit v, input logic [7:0] d, input bit ack);
        if (m_ready) begin
            if (ack) begin
                m_ready = 0; m_ovf = 0; m_ovr = 0; m_disc = 0;
                cur.delete();
                if (v && d != SKIP && d != TERM) begin
                    m_mem[0] = d;
                    cur.push_back(d);
                end
            end else if (v && d != SKIP) begin
                m_ovr = 1;
            end
        end else if (v && d != SKIP) begin
            if (d == TERM) begin
                if (m_disc) begin
                    m_len = DEPTH; m_ready = 1; m_disc = 0;
                end else if (cur.size() > 0) begin
                    m_len = cur.size(); m_ready = 1;
                end
            end else if (!m_disc) begin
                if (cur.size() < DEPTH) begin
                    m_mem[cur.size()] = d;
                    cur.push_back(d);
                end else begin
                    m_ovf = 1; m_disc = 1;
                end
            end
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, check all outputs.
    task automatic cycle(input bit v, input logic [7:0] d, input bit ack, input logic [3:0] a);
        logic [7:0] exp_rd;
        rx_valid = v; rx_data = d; line_ack = ack; rd_addr = a;
        exp_rd = (rst_n && int'(a) < m_len) ? m_mem[a] : 8'h20;
        @(posedge clk);
        if (rst_n) model_step(v, d, ack);
        else       model_reset();
        #1;
        check("rd_data",    rd_data,    exp_rd);
        check("line_ready", line_ready, 16'(m_ready));
        check("line_len",   line_len,   16'(m_len));
        check("overflow",   overflow,   16'(m_ovf));
        check("overrun",    overrun,    16'(m_ovr));
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) cycle(1, s[i], 0, 4'd0);
    endtask

    task automatic idle_read(input logic [3:0] a);
        cycle(0, 8'h00, 0, a);
    endtask

    initial begin
        rst_n = 0; rx_valid = 0; rx_data = 8'h00; line_ack = 0; rd_addr = 4'd0;
        model_reset();
        cycle(0, 8'h00, 0, 4'd0);
        cycle(1, 8'h41, 0, 4'd3);
        check("reset_len", line_len, 16'd0);
        check("reset_rd",  rd_data,  16'h20);
        rst_n = 1;

        // 1: "Hi\r"
        send_str("Hi");
        cycle(1, TERM, 0, 4'd0);
        check("t1_ready", line_ready, 16'd1);
        check("t1_len",   line_len,   16'd2);
        idle_read(4'd0); check("t1_rd0", rd_data, 16'h48);
        idle_read(4'd1); check("t1_rd1", rd_data, 16'h69);
        idle_read(4'd2); check("t1_rd2", rd_data, 16'h20);
        cycle(0, 8'h00, 1, 4'd0);

        // 2: empty line ignored, SKIP dropped
        cycle(1, TERM, 0, 4'd0);
        check("t2_empty", line_ready, 16'd0);
        send_str("A"); cycle(1, SKIP, 0, 4'd0); send_str("B");
        cycle(1, TERM, 0, 4'd0);
        check("t2_len", line_len, 16'd2);
        check("t2_ovf", overflow, 16'd0);
        idle_read(4'd0); check("t2_rd0", rd_data, 16'h41);
        idle_read(4'd1); check("t2_rd1", rd_data, 16'h42);
        cycle(0, 8'h00, 1, 4'd0);

        // 3: overflow truncates at DEPTH
        for (int i = 0; i < 20; i++) cycle(1, 8'h41, 0, 4'd0);
        cycle(1, TERM, 0, 4'd0);
        check("t3_len", line_len, 16'd16);
        check("t3_ovf", overflow, 16'd1);
        for (int i = 0; i < 16; i++) begin
            idle_read(4'(i)); check("t3_rd", rd_data, 16'h41);
        end

        // 4: overrun while held, then release
        cycle(1, 8'h78, 0, 4'd5);
        check("t4_ovr", overrun,  16'd1);
        check("t4_len", line_len, 16'd16);
        idle_read(4'd5); check("t4_rd5", rd_data, 16'h41);
        cycle(0, 8'h00, 1, 4'd0);
        check("t4_rdy", line_ready, 16'd0);
        check("t4_ovr0", overrun,   16'd0);
        check("t4_ovf0", overflow,  16'd0);

        // 5: ack coincident with a data byte
        send_str("Z"); cycle(1, TERM, 0, 4'd0);
        cycle(1, 8'h51, 1, 4'd0);
        cycle(1, TERM, 0, 4'd0);
        check("t5_len", line_len, 16'd1);
        check("t5_ovr", overrun,  16'd0);
        idle_read(4'd0); check("t5_rd0", rd_data, 16'h51);
        cycle(0, 8'h00, 1, 4'd0);

        // 6: reset mid-line discards the partial line
        send_str("Hel");
        rst_n = 0;
        cycle(0, 8'h00, 0, 4'd0);
        check("t6_rst_rd", rd_data, 16'h20);
        rst_n = 1;
        send_str("ok"); cycle(1, TERM, 0, 4'd0);
        check("t6_len", line_len, 16'd2);
        idle_read(4'd0); check("t6_rd0", rd_data, 16'h6F);
        idle_read(4'd1); check("t6_rd1", rd_data, 16'h6B);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int         r;
            logic [7:0] d;
            bit         v, ack;
            r = int'($urandom_range(0, 99));
            if (r < 7)       d = TERM;
            else if (r < 12) d = SKIP;
            else             d = 8'(8'h41 + $urandom_range(0, 25));
            v   = ($urandom_range(0, 3) != 0);
            ack = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 399) == 0) begin
                rst_n = 0;
                cycle(v, d, ack, 4'($urandom_range(0, 15)));
                rst_n = 1;
            end else begin
                cycle(v, d, ack, 4'($urandom_range(0, 15)));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
